// File: rtl/tea_pkg.sv
// Shared TEA constants and FSM encoding used by the encryptor and decryptor.
package tea_pkg;
    localparam logic [31:0] TEA_DELTA        = 32'h9E3779B9;
    localparam logic [31:0] TEA_DEC_SUM_INIT = 32'hC6EF3720;  // TEA_DELTA * 32 mod 2^32
    localparam int          TEA_ROUNDS       = 32;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        PROCESSING = 2'b01,
        DONE       = 2'b11
    } tea_state_e;
endpackage

// File: rtl/tea_dec_round.sv
// One combinational TEA decryption round; v1 is updated first, and v0 then uses the new v1.
import tea_pkg::*;

module tea_dec_round (
    input  logic [31:0]  v0,
    input  logic [31:0]  v1,
    input  logic [31:0]  sum,
    input  logic [127:0] key,
    output logic [31:0]  v0_nxt,
    output logic [31:0]  v1_nxt
);
    logic [31:0] k0, k1, k2, k3;

    assign {k0, k1, k2, k3} = key;

    assign v1_nxt = v1 - (((v0 << 4) + k2) ^ (v0 + sum) ^ ((v0 >> 5) + k3));
    assign v0_nxt = v0 - (((v1_nxt << 4) + k0) ^ (v1_nxt + sum) ^ ((v1_nxt >> 5) + k1));
endmodule

// File: rtl/tea_decryptor.sv
// Constant-time TEA block decryptor, one round per clock, AXI-Stream in/out.
// Build option: TEA_DEC_ZEROIZE_EN clears data, key and sum registers when the output is accepted.
import tea_pkg::*;

module tea_decryptor #(
    parameter int ROUNDS = TEA_ROUNDS
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [127:0] i_key,
    input  logic         i_axis_valid_s,
    output logic         o_axis_ready_s,
    input  logic [63:0]  i_axis_data_s,
    output logic         o_axis_valid_m,
    input  logic         i_axis_ready_m,
    output logic [63:0]  o_axis_data_m
);
    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

    tea_state_e   state, state_nxt;
    logic [31:0]  v0, v1, sum;
    logic [127:0] key_q;
    logic [4:0]   round_counter;
    logic [31:0]  v0_rnd, v1_rnd;

    tea_dec_round u_round (
        .v0     (v0),
        .v1     (v1),
        .sum    (sum),
        .key    (key_q),
        .v0_nxt (v0_rnd),
        .v1_nxt (v1_rnd)
    );

    // Ready is masked by reset so nothing is accepted while reset is held.
    assign o_axis_ready_s = (state == IDLE) && !i_rst;
    assign o_axis_valid_m = (state == DONE);
    assign o_axis_data_m  = {v0, v1};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (i_axis_valid_s) state_nxt = PROCESSING;
            PROCESSING: if (round_counter == LAST_ROUND) state_nxt = DONE;
            DONE:       if (i_axis_ready_m) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v0            <= '0;
            v1            <= '0;
            key_q         <= '0;
            sum           <= '0;
            round_counter <= '0;
        end else begin
            case (state)
                IDLE: if (i_axis_valid_s) begin
                    {v0, v1}      <= i_axis_data_s;
                    key_q         <= i_key;
                    sum           <= TEA_DEC_SUM_INIT;
                    round_counter <= '0;
                end
                PROCESSING: begin
                    v0  <= v0_rnd;
                    v1  <= v1_rnd;
                    sum <= sum - TEA_DELTA;
                    // Counter saturates at the last round so DONE always sees 31.
                    if (round_counter != LAST_ROUND) round_counter <= round_counter + 5'd1;
                end
`ifdef TEA_DEC_ZEROIZE_EN
                DONE: if (i_axis_ready_m) begin
                    v0    <= '0;
                    v1    <= '0;
                    key_q <= '0;
                    sum   <= '0;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule
